// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master and its GPIO target.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // gpio_top register byte offsets
  localparam logic [7:0] RGPIO_IN    = 8'h00;
  localparam logic [7:0] RGPIO_OUT   = 8'h04;
  localparam logic [7:0] RGPIO_OE    = 8'h08;
  localparam logic [7:0] RGPIO_INTE  = 8'h0C;
  localparam logic [7:0] RGPIO_PTRIG = 8'h10;
  localparam logic [7:0] RGPIO_AUX   = 8'h14;
  localparam logic [7:0] RGPIO_CTRL  = 8'h18;
  localparam logic [7:0] RGPIO_INTS  = 8'h1C;
  localparam logic [7:0] RGPIO_ECLK  = 8'h20;
  localparam logic [7:0] RGPIO_NEC   = 8'h24;

  localparam logic RSP_OKAY   = 1'b0;
  localparam logic RSP_SLVERR = 1'b1;

  localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: valid/ready command in, APB transfer out,
// valid/ready response back, with misalignment and hung-slave reporting.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = {WAIT_W{1'b1}};

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_d      = wait_q;
    wait_inc    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          if (cmd_write) pwdata_d = cmd_wdata;
          if (cmd_addr[1:0] != 2'b00) begin
            state_d     = ST_RESP;
            rsp_err_d   = RSP_SLVERR;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_SETUP;
            wait_d  = '0;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          state_d     = ST_RESP;
          rsp_err_d   = RSP_OKAY;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else begin
          wait_d = wait_inc;
          // pready on the final allowed edge takes the success branch above
          if (wait_inc >= TIMEOUT_CNT) begin
            state_d     = ST_RESP;
            rsp_err_d   = RSP_SLVERR;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_q      <= wait_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a behavioural APB slave.
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, ps, pe;
  bit moved;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Present a command and complete the handshake; returns just after edge N.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0BAD_0BAD;
  endtask

  // Slave with w wait states (pready on the (w+1)th ACCESS cycle); counts cycles until rsp_valid.
  task automatic run_xfer(input int w, input logic [31:0] rd, output int l,
                          output int nps, output int npe, output bit mv);
    int acc;
    logic [31:0] a0, d0;
    l = 0; nps = 0; npe = 0; mv = 1'b0; acc = 0;
    a0 = paddr; d0 = pwdata;
    while (!rsp_valid && l < 300) begin
      if (psel) nps++;
      if (penable) begin
        npe++;
        acc++;
        if (paddr !== a0 || pwdata !== d0) mv = 1'b1;
      end
      pready = penable && (acc > w);
      prdata = pready ? rd : 32'hDEAD_BEEF;
      tick();
      l++;
    end
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
  endtask

  task automatic finish_rsp(input string tag);
    tick();
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; pready = 1'b0; prdata = 32'hDEAD_BEEF;

    // Reset
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    preset = 1'b1;
    #2;
    check("rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
    tick();
    check("rel_cmd_ready_post", 32'(cmd_ready), 32'd1);

    // Write, zero waits
    issue(1'b1, 32'(RGPIO_OE), 32'hFFFF_0000);
    check("wr_setup_psel", 32'(psel), 32'd1);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_paddr", paddr, 32'h0000_0008);
    check("wr_pwrite", 32'(pwrite), 32'd1);
    check("wr_pwdata", pwdata, 32'hFFFF_0000);
    check("wr_busy_ready", 32'(cmd_ready), 32'd0);
    run_xfer(0, 32'h1111_1111, lat, ps, pe, moved);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_psel_cycles", 32'(ps), 32'd2);
    check("wr_penable_cycles", 32'(pe), 32'd1);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_rsp_psel", 32'(psel), 32'd0);
    finish_rsp("wr");

    // Read, 3 wait states; pwdata keeps the last write value
    issue(1'b0, 32'(RGPIO_OUT), 32'h0);
    check("rd_pwrite", 32'(pwrite), 32'd0);
    check("rd_pwdata_hold", pwdata, 32'hFFFF_0000);
    run_xfer(3, 32'hA5A5_A5A5, lat, ps, pe, moved);
    check("rd_latency", 32'(lat), 32'd5);
    check("rd_penable_cycles", 32'(pe), 32'd4);
    check("rd_addr_stable", 32'(moved), 32'd0);
    check("rd_paddr", paddr, 32'h0000_0004);
    check("rd_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    finish_rsp("rd");

    // Misaligned read
    issue(1'b0, 32'h0000_0006, 32'h0);
    run_xfer(0, 32'h2222_2222, lat, ps, pe, moved);
    check("mis_latency", 32'(lat), 32'd0);
    check("mis_psel_cycles", 32'(ps), 32'd0);
    check("mis_rsp_err", 32'(rsp_err), 32'd1);
    check("mis_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("mis_psel_after", 32'(psel), 32'd0);
    check("mis_ready_back", 32'(cmd_ready), 32'd1);

    // Timeout with pready stuck low
    issue(1'b0, 32'(RGPIO_CTRL), 32'h0);
    run_xfer(1000, 32'h3333_3333, lat, ps, pe, moved);
    check("to_latency", 32'(lat), 32'd17);
    check("to_penable_cycles", 32'(pe), 32'd16);
    check("to_psel_cycles", 32'(ps), 32'd17);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_psel_drop", 32'(psel), 32'd0);
    finish_rsp("to");

    // pready on the last allowed edge wins
    issue(1'b0, 32'(RGPIO_AUX), 32'h0);
    run_xfer(15, 32'h5A5A_0F0F, lat, ps, pe, moved);
    check("edge_latency", 32'(lat), 32'd17);
    check("edge_rsp_err", 32'(rsp_err), 32'd0);
    check("edge_rsp_rdata", rsp_rdata, 32'h5A5A_0F0F);
    finish_rsp("edge");

    // Normal command after the timeout
    issue(1'b0, 32'(RGPIO_INTS), 32'h0);
    check("ints_paddr", paddr, 32'h0000_001C);
    run_xfer(0, 32'h0000_00C3, lat, ps, pe, moved);
    check("ints_latency", 32'(lat), 32'd2);
    check("ints_rsp_err", 32'(rsp_err), 32'd0);
    check("ints_rsp_rdata", rsp_rdata, 32'h0000_00C3);
    finish_rsp("ints");

    // Response backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'(RGPIO_INTE), 32'h0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'(RGPIO_ECLK);
    run_xfer(1, 32'h1234_5678, lat, ps, pe, moved);
    check("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("bp_rsp_err", 32'(rsp_err), 32'd0);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_psel", 32'(psel), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    finish_rsp("bp");

    // Reset during ACCESS
    issue(1'b0, 32'(RGPIO_PTRIG), 32'h0);
    tick();
    check("mid_penable", 32'(penable), 32'd1);
    check("mid_psel", 32'(psel), 32'd1);
    #2;
    preset = 1'b0;
    #1;
    check("mid_rst_psel", 32'(psel), 32'd0);
    check("mid_rst_penable", 32'(penable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_paddr", paddr, 32'd0);
    tick();
    preset = 1'b1;
    tick();
    check("mid_rel_ready", 32'(cmd_ready), 32'd1);
    check("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
